fifo_wr_arbiter: RTL and testbench

Frame-atomic, two-requester round-robin arbiter that shares the write port of one sync_fifo instance in the TX MAC path. It is used, for example, to merge client data frames (requester 0) and PAUSE/control frames (requester 1). Once a requester is granted, it keeps the FIFO write port until its last word is accepted, so frames never interleave in the FIFO. The block also provides per-requester frame counters and a mid-frame stall watchdog.

---
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Frame-atomic two-requester round-robin arbiter for one shared FIFO write port.
// Provides per-requester frame counters and a mid-frame stall watchdog.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH  = 36,
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_abort,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  frames0,
  output logic [CNT_WIDTH-1:0]  frames1,
  output logic [CNT_WIDTH-1:0]  aborts
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [15:0] StallLim = 16'(STALL_LIMIT);

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic [15:0]          stall_q, stall_d;
  logic                 abort_q, abort_d;
  logic [CNT_WIDTH-1:0] frames0_q, frames0_d;
  logic [CNT_WIDTH-1:0] frames1_q, frames1_d;
  logic [CNT_WIDTH-1:0] aborts_q, aborts_d;

  logic own0, own1, own_any;
  logic fire0, fire1, fire, fire_last;
  logic own_valid, stall_hit;

  // Handshake and pass-through datapath are purely combinational: zero latency.
  always_comb begin
    own0       = (state_q == OWN0);
    own1       = (state_q == OWN1);
    own_any    = own0 | own1;
    req0_ready = own0 & ~fifo_full;
    req1_ready = own1 & ~fifo_full;
    fire0      = req0_valid & req0_ready;
    fire1      = req1_valid & req1_ready;
    fire       = fire0 | fire1;
    fire_last  = (fire0 & req0_last) | (fire1 & req1_last);
    own_valid  = (own0 & req0_valid) | (own1 & req1_valid);
    // Backpressure cycles (valid high, full high) never advance the watchdog.
    stall_hit  = own_any & ~own_valid & ((stall_q + 16'd1) == StallLim);
  end

  always_comb begin
    fifo_wr_data = '0;
    if (own0) begin
      fifo_wr_data = req0_data;
    end else if (own1) begin
      fifo_wr_data = req1_data;
    end
  end

  assign fifo_wr_en    = fire;
  assign fifo_wr_abort = abort_q;
  assign grant         = {own1, own0};
  assign frames0       = frames0_q;
  assign frames1       = frames1_q;
  assign aborts        = aborts_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    stall_d   = stall_q;
    abort_d   = 1'b0;
    frames0_d = frames0_q;
    frames1_d = frames1_q;
    aborts_d  = aborts_q;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (req0_valid && req1_valid) begin
          // Tie goes to whoever was not served last.
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0_valid) begin
          state_d = OWN0;
        end else if (req1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (fire) begin
          stall_d = '0;
          if (fire_last) begin
            state_d = IDLE;
            last_d  = own1;
            if (own0) begin
              frames0_d = frames0_q + CNT_WIDTH'(1);
            end else begin
              frames1_d = frames1_q + CNT_WIDTH'(1);
            end
          end
        end else if (!own_valid) begin
          if (stall_hit) begin
            state_d  = IDLE;
            last_d   = own1;
            stall_d  = '0;
            abort_d  = 1'b1;
            aborts_d = aborts_q + CNT_WIDTH'(1);
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        stall_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      stall_q   <= '0;
      abort_q   <= 1'b0;
      frames0_q <= '0;
      frames1_q <= '0;
      aborts_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      stall_q   <= stall_d;
      abort_q   <= abort_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
      aborts_q  <= aborts_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (STALL_LIMIT=8, 4-bit counters
// so the frame-counter wrap is reachable in a short run).
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 36;
  localparam int unsigned SL = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_last = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0, req1_last = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          fifo_full = 1'b0;
  logic          req0_ready, req1_ready, fifo_wr_en, fifo_wr_abort;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0]    grant;
  logic [CW-1:0] frames0, frames1, aborts;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .STALL_LIMIT(SL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .req1_ready   (req1_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_abort(fifo_wr_abort),
    .grant        (grant),
    .frames0      (frames0),
    .frames1      (frames1),
    .aborts       (aborts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_last  = 1'b0;
    req1_valid = 1'b0;
    req1_last  = 1'b0;
    fifo_full  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, w1, w;
    logic [1:0]    exp_grant;
    logic          exp_en, owner, full_c;
    logic [DW-1:0] exp_data;

    // Reset state
    do_reset();
    settle();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_abort", 64'(fifo_wr_abort), 64'd0);
    check("rst_frames0", 64'(frames0), 64'd0);
    check("rst_frames1", 64'(frames1), 64'd0);
    check("rst_aborts", 64'(aborts), 64'd0);

    // Single 4-word frame on requester 0
    req0_valid = 1'b1;
    req0_data  = 36'hA_0000_0000;
    req0_last  = 1'b0;
    settle();
    check("single_idle_grant", 64'(grant), 64'd0);
    check("single_idle_ready", 64'(req0_ready), 64'd0);
    check("single_idle_wr_en", 64'(fifo_wr_en), 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      req0_data = 36'hA_0000_0000 + 36'(i);
      req0_last = (i == 3);
      settle();
      check("single_grant", 64'(grant), 64'd1);
      check("single_wr_en", 64'(fifo_wr_en), 64'd1);
      check("single_wr_data", 64'(fifo_wr_data), 64'(36'hA_0000_0000 + 36'(i)));
      step();
    end
    req0_valid = 1'b0;
    req0_last  = 1'b0;
    settle();
    check("single_after_grant", 64'(grant), 64'd0);
    check("single_frames0", 64'(frames0), 64'd1);

    // Contention: 3-word frames on both sides, order 0,1,0,1 with idle gaps
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    w0 = 0;
    w1 = 0;
    for (int c = 0; c < 16; c++) begin
      req0_data = {4'h0, 32'(w0)};
      req0_last = ((w0 % 3) == 2);
      req1_data = {4'h1, 32'(w1)};
      req1_last = ((w1 % 3) == 2);
      settle();
      if ((c % 4) == 0) begin
        exp_grant = 2'b00;
        exp_en    = 1'b0;
        exp_data  = '0;
      end else begin
        owner     = ((c / 4) % 2) == 1;
        exp_grant = owner ? 2'b10 : 2'b01;
        exp_en    = 1'b1;
        exp_data  = {3'b000, owner, 32'(((c / 8) * 3) + (c % 4) - 1)};
      end
      check("cont_grant", 64'(grant), 64'(exp_grant));
      check("cont_wr_en", 64'(fifo_wr_en), 64'(exp_en));
      if (exp_en) check("cont_wr_data", 64'(fifo_wr_data), 64'(exp_data));
      if (req0_ready) w0++;
      if (req1_ready) w1++;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    check("cont_frames0", 64'(frames0), 64'd2);
    check("cont_frames1", 64'(frames1), 64'd2);

    // Backpressure: full held for 3 cycles after word 2 of a 5-word frame
    do_reset();
    req1_valid = 1'b1;
    w = 0;
    for (int c = 0; c < 9; c++) begin
      full_c    = (c >= 3) && (c <= 5);
      fifo_full = full_c;
      req1_data = {4'h5, 32'(w)};
      req1_last = (w == 4);
      settle();
      if (c == 0) begin
        check("bp_idle_grant", 64'(grant), 64'd0);
      end else begin
        check("bp_grant", 64'(grant), 64'd2);
        check("bp_ready", 64'(req1_ready), 64'(!full_c));
        check("bp_wr_en", 64'(fifo_wr_en), 64'(!full_c));
        if (!full_c) begin
          check("bp_wr_data", 64'(fifo_wr_data),
                64'({4'h5, 32'((c < 3) ? (c - 1) : (c - 4))}));
        end
        check("bp_no_abort", 64'(fifo_wr_abort), 64'd0);
      end
      if (req1_ready) w++;
      step();
    end
    fifo_full  = 1'b0;
    req1_valid = 1'b0;
    req1_last  = 1'b0;
    settle();
    check("bp_frames1", 64'(frames1), 64'd1);
    check("bp_aborts", 64'(aborts), 64'd0);
    check("bp_end_grant", 64'(grant), 64'd0);

    // Watchdog: 2 words then requester 0 goes silent; requester 1 pending
    do_reset();
    req0_valid = 1'b1;
    req0_last  = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      req0_data = 36'h3_0000_0000 + 36'(i);
      settle();
      check("wd_word_wr_en", 64'(fifo_wr_en), 64'd1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_last  = 1'b0;
    settle();
    check("wd_k0_abort", 64'(fifo_wr_abort), 64'd0);
    check("wd_k0_grant", 64'(grant), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("wd_abort", 64'(fifo_wr_abort), 64'(k == 8));
      check("wd_grant", 64'(grant), (k == 8) ? 64'd0 : 64'd1);
      check("wd_wr_en", 64'(fifo_wr_en), 64'd0);
    end
    check("wd_aborts", 64'(aborts), 64'd1);
    check("wd_frames0", 64'(frames0), 64'd0);
    step();
    check("wd_next_grant", 64'(grant), 64'd2);
    check("wd_abort_clear", 64'(fifo_wr_abort), 64'd0);

    // Reset during word 3 of requester 1's frame
    for (int i = 0; i < 2; i++) begin
      req1_data = 36'h7_0000_0000 + 36'(i);
      settle();
      check("mrst_word_wr_en", 64'(fifo_wr_en), 64'd1);
      step();
    end
    req1_data = 36'h7_0000_0002;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_last  = 1'b0;
    settle();
    check("mrst_grant", 64'(grant), 64'd0);
    check("mrst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("mrst_aborts", 64'(aborts), 64'd0);
    check("mrst_frames0", 64'(frames0), 64'd0);
    check("mrst_frames1", 64'(frames1), 64'd0);
    step();
    check("mrst_tie_grant", 64'(grant), 64'd1);

    // Frame-counter wrap: 16 single-word frames on requester 0 (CNT_WIDTH=4)
    do_reset();
    req0_valid = 1'b1;
    req0_last  = 1'b1;
    req0_data  = 36'h9_0000_0001;
    for (int f = 1; f <= 16; f++) begin
      step();
      step();
      if (f >= 15) check("wrap_frames0", 64'(frames0), 64'(f % 16));
    end
    req0_valid = 1'b0;
    settle();
    check("wrap_frames1", 64'(frames1), 64'd0);
    check("wrap_aborts", 64'(aborts), 64'd0);
    check("wrap_grant", 64'(grant), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
